// File: rtl/sort_pkg.sv
// sort_pkg: FSM state encoding, default sorter sizes and the sort-peripheral address map
// shared by sort_stream_ctrl and its watchdog.
package sort_pkg;
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SRST,
        ST_RD,
        ST_PUSH,
        ST_WAIT,
        ST_PRESENT,
        ST_ADV,
        ST_SETTLE,
        ST_DONE
    } state_t;
    localparam int SORT_DATA_WIDTH    = 32;
    localparam int SORT_LOG_INPUT_NUM = 5;
    localparam logic [31:0] SORT_ADDR_RST    = 32'h4000_0000;
    localparam logic [31:0] SORT_ADDR_DIN    = 32'h4000_0004;
    localparam logic [31:0] SORT_ADDR_NOW1   = 32'h4000_0008;
    localparam logic [31:0] SORT_ADDR_YVALID = 32'h4000_000C;
    localparam logic [31:0] SORT_ADDR_DOUT   = 32'h4000_0010;
    localparam logic [31:0] SORT_ADDR_NOW2   = 32'h4000_0014;
    localparam logic [31:0] SORT_MEM_BASE    = 32'h3000_0000;
endpackage

// File: rtl/sort_wdog_cnt.sv
// sort_wdog_cnt: watchdog for the WAIT state; expired is high on the TIMEOUT_CYCLES-th
// consecutive enabled cycle, and the count restarts whenever en drops.
module sort_wdog_cnt #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = en ? cnt_q + 16'd1 : 16'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign expired = en && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads N words from source memory into sort_top and drains sorted results
// onto a valid/ready stream. Define SORT_TIMEOUT_EN to add the WAIT-state watchdog.
module sort_stream_ctrl
    import sort_pkg::*;
#(
    parameter int LOG_INPUT_NUM   = SORT_LOG_INPUT_NUM,
    parameter int DATA_WIDTH      = SORT_DATA_WIDTH,
    parameter int SRC_AW          = LOG_INPUT_NUM,
    parameter int SORT_RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [SRC_AW-1:0]     src_rd_addr,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic                  sort_rst,
    output logic [DATA_WIDTH-1:0] sort_din,
    output logic                  sort_now1,
    output logic                  sort_now2,
    input  logic                  sort_y_valid,
    input  logic [DATA_WIDTH-1:0] sort_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  timeout
);
    localparam logic [LOG_INPUT_NUM:0] LAST = (LOG_INPUT_NUM+1)'((1 << LOG_INPUT_NUM) - 1);

    state_t                  state_q, state_d;
    logic [LOG_INPUT_NUM:0]  idx_q, idx_d, out_cnt_q, out_cnt_d;
    logic [15:0]             rst_cnt_q, rst_cnt_d;
    logic                    sort_rst_q, sort_rst_d, now1_q, now1_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d, m_data_q, m_data_d;
    logic                    wdog_expired;

`ifdef SORT_TIMEOUT_EN
    logic timeout_q, timeout_d;
    sort_wdog_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk(clk),
        .rst(rst),
        .en(state_q == ST_WAIT),
        .expired(wdog_expired)
    );
    assign timeout = timeout_q;
`else
    assign wdog_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_cnt_d  = out_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        sort_rst_d = sort_rst_q;
        din_d      = din_q;
        now1_d     = 1'b0;
        m_data_d   = m_data_q;
`ifdef SORT_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_SRST;
                rst_cnt_d  = '0;
                idx_d      = '0;
                sort_rst_d = 1'b1;
`ifdef SORT_TIMEOUT_EN
                timeout_d  = 1'b0;
`endif
            end
            ST_SRST: begin
                rst_cnt_d  = rst_cnt_q + 16'd1;
                if (rst_cnt_q == 16'(SORT_RST_CYCLES - 1)) begin
                    state_d    = ST_RD;
                    sort_rst_d = 1'b0;
                end
            end
            ST_RD: state_d = ST_PUSH;
            // din and now1 are registered together so the sorter sees them in the same cycle
            ST_PUSH: begin
                din_d   = src_rd_data;
                now1_d  = 1'b1;
                state_d = (idx_q == LAST) ? ST_WAIT : ST_RD;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
            end
            ST_WAIT: begin
                if (wdog_expired) begin
                    state_d    = ST_DONE;
                    sort_rst_d = 1'b1;
`ifdef SORT_TIMEOUT_EN
                    timeout_d  = 1'b1;
`endif
                end else if (sort_y_valid) begin
                    out_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                m_data_d = sort_dout;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: if (m_ready) state_d = (out_cnt_q == LAST) ? ST_DONE : ST_ADV;
            ST_ADV: begin
                out_cnt_d = out_cnt_q + 1'b1;
                state_d   = ST_SETTLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            out_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            sort_rst_q <= 1'b1;
            din_q      <= '0;
            now1_q     <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_cnt_q  <= out_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            sort_rst_q <= sort_rst_d;
            din_q      <= din_d;
            now1_q     <= now1_d;
            m_data_q   <= m_data_d;
        end
    end

`ifdef SORT_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end
`endif

    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_DONE;
    assign src_rd_en   = state_q == ST_RD;
    assign src_rd_addr = idx_q[SRC_AW-1:0];
    assign sort_rst    = sort_rst_q;
    assign sort_din    = din_q;
    assign sort_now1   = now1_q;
    assign sort_now2   = state_q == ST_ADV;
    assign m_valid     = state_q == ST_PRESENT;
    assign m_data      = m_data_q;
endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Sequencer that sits directly in front of sort_top, replacing CPU-driven writes to the sorter's reset, din, now1 and now2 registers.
- Reads 2**LOG_INPUT_NUM words from the sort-input memory through a 1-cycle-latency read port and pushes them into the sorter.
- Waits for y_valid, then drains sorted results onto a valid/ready output stream consumed by the peripheral/write-back logic.
- Software only pulses start and polls busy/done.

Parameters:
- LOG_INPUT_NUM, 5, log2 of the element count N = 2**LOG_INPUT_NUM per sort run.
- DATA_WIDTH, 32, element width; must match sort_top.
- SRC_AW, LOG_INPUT_NUM, width of the source word index.
- SORT_RST_CYCLES, 2, cycles sort_rst is held high at the start of each run (≥1).
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with SORT_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes.
- src_rd_en  out  1  source memory read strobe.
- src_rd_addr  out  SRC_AW  source word index, 0..N-1.
- src_rd_data  in  DATA_WIDTH  read data, valid the cycle after src_rd_en.
- sort_rst  out  1  sorter reset.
- sort_din  out  DATA_WIDTH  sorter input data.
- sort_now1  out  1  sorter input strobe.
- sort_now2  out  1  sorter output-advance strobe.
- sort_y_valid  in  1  sorter results-ready flag.
- sort_dout  in  DATA_WIDTH  current sorter output.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  DATA_WIDTH  output stream data.
- timeout  out  1  sticky watchdog error (SORT_TIMEOUT_EN only).

Behaviour:
- Reset values (async, all outputs):
  - busy=0, done=0, src_rd_en=0, src_rd_addr=0, sort_din=0, sort_now1=0, sort_now2=0, m_valid=0, m_data=0, timeout=0.
  - sort_rst=1: the sorter is held in reset while idle after reset.
  - FSM goes to IDLE; counters go to 0.
- States: IDLE, SRST, RD, PUSH, WAIT, PRESENT, ADV, SETTLE, DONE.
- IDLE:
  - sort_rst holds its last value.
  - start=1 → SRST, rst_cnt=0, idx=0.
  - start in any other state is ignored (no queueing).
- SRST:
  - sort_rst=1 for SORT_RST_CYCLES cycles, then → RD with sort_rst=0.
- RD:
  - src_rd_en=1 for one cycle, src_rd_addr=idx → PUSH.
- PUSH (cycle after RD):
  - sort_din<=src_rd_data and sort_now1=1, both in the same cycle for exactly one cycle.
  - idx==N-1 → WAIT; otherwise idx++ → RD.
  - Exactly N now1 pulses per run; load throughput is 1 element per 2 cycles.
  - sort_din holds its value after the pulse.
- WAIT:
  - Stays until sort_y_valid=1 is sampled.
  - Then out_cnt=0 and → SETTLE; SETTLE captures the first result.
- SETTLE:
  - m_data<=sort_dout, m_valid<=1 → PRESENT.
- PRESENT:
  - m_valid=1, m_data stable.
  - On m_valid&&m_ready: m_valid<=0.
    - If out_cnt==N-1 → DONE.
    - Otherwise → ADV.
  - While m_ready=0, m_valid and m_data are held indefinitely.
- ADV:
  - sort_now2=1 for one cycle, out_cnt++ → SETTLE.
  - Output throughput: 1 element per 3 cycles with m_ready tied high.
- DONE:
  - done=1 for one cycle → IDLE.
  - sort_rst stays 0 so the sorter state remains inspectable until the next start.
- Counters:
  - idx and out_cnt are LOG_INPUT_NUM+1 bits wide, so no wrap at N-1.
  - src_rd_addr is idx[SRC_AW-1:0].
- Reset mid-run:
  - Returns to the reset values above immediately.
  - sort_rst=1 within the same cycle (asynchronous).
  - Any partially loaded sorter contents are discarded.
- sort_y_valid dropping during the drain is ignored; drain count is authoritative.

Optional Feature:
- SORT_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES sets timeout=1 (sticky until rst or the next accepted start), pulses done, and returns to IDLE with sort_rst=1.
- Not defined:
  - WAIT waits forever; the timeout port is tied to 0.
  - No counter logic is synthesized.

Decomposition:
- Shared package sort_pkg holds:
  - the FSM state enum (4-bit);
  - the default DATA_WIDTH/LOG_INPUT_NUM constants;
  - the sort-peripheral address constants (0x4000_0000 reset, _04 din, _08 now1, _0C y_valid, _10 dout, _14 now2, 0x3000_0000 sort memory base).
- One natural sub-module, sort_wdog_cnt: the watchdog counter, instantiated only under SORT_TIMEOUT_EN.
- Everything else stays in one FSM.

Test Plan:
- LOG_INPUT_NUM=2, memory {7,3,9,1}, sort model with y_valid 5 cycles after the 4th now1, m_ready=1:
  - exactly 4 now1 pulses with din 7,3,9,1;
  - m_data 1,3,7,9;
  - done pulse 1 cycle after the last handshake.
- Same run with m_ready low for 10 cycles on the 2nd output:
  - m_valid stays 1 and m_data stays 3;
  - no now2 pulse during the stall.
- start pulsed again mid-load: ignored; exactly 4 now1 pulses and one done.
- rst asserted after the 2nd now1:
  - all outputs return to reset values and sort_rst=1 in the same cycle;
  - a new start reloads from address 0.
- With SORT_TIMEOUT_EN, TIMEOUT_CYCLES=20, y_valid never asserted:
  - timeout=1 and done pulses 20 cycles into WAIT;
  - busy=0 afterwards.
- Back-to-back runs (start in the cycle after done):
  - second run asserts sort_rst for 2 cycles;
  - output order is correct again.
